// File: rtl/usb_tx_serializer.sv
// USB transmit line stage: pulls bits from the TX FIFO, bit-stuffs, NRZI-encodes,
// drives D+/D- and closes each packet with SE0, SE0, J. Line changes follow bit_en.
module usb_tx_serializer #(
  parameter int STUFF_LEN = 6,
  parameter int CNT_W     = $clog2(STUFF_LEN + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic bit_en,
  input  logic start,
  input  logic fifo_empty,
  input  logic fifo_bit,
  output logic fifo_re,
  output logic dp,
  output logic dm,
  output logic busy,
  output logic done
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_SEND = 3'd1;
  localparam logic [2:0] ST_EOP1 = 3'd2;
  localparam logic [2:0] ST_EOP2 = 3'd3;
  localparam logic [2:0] ST_EOP3 = 3'd4;
  localparam logic [2:0] ST_DONE = 3'd5;

  localparam logic [CNT_W-1:0] STUFF_MAX = CNT_W'(STUFF_LEN);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic [2:0]       state_q, state_d;
  logic             lvl_q, lvl_d;
  logic [CNT_W-1:0] ones_q, ones_d;
  logic             dp_q, dp_d;
  logic             dm_q, dm_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             se0_d;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    state_d = state_q;
    lvl_d   = lvl_q;
    ones_d  = ones_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    fifo_re = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SEND;
          busy_d  = 1'b1;
          ones_d  = '0;
        end
      end
      ST_SEND: begin
        if (bit_en) begin
          if (ones_q == STUFF_MAX) begin
            // Stuffed zero takes priority, so a run of ones at the very end is still closed.
            lvl_d  = ~lvl_q;
            ones_d = '0;
          end else if (!fifo_empty) begin
            fifo_re = ~rst;
            if (fifo_bit) begin
              ones_d = ones_q + CNT_ONE;
            end else begin
              ones_d = '0;
              lvl_d  = ~lvl_q;
            end
          end else begin
            state_d = ST_EOP1;
          end
        end
      end
      ST_EOP1: begin
        if (bit_en) state_d = ST_EOP2;
      end
      ST_EOP2: begin
        if (bit_en) begin
          state_d = ST_EOP3;
          lvl_d   = 1'b1;
        end
      end
      ST_EOP3: begin
        if (bit_en) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        lvl_d   = 1'b1;
        ones_d  = '0;
        busy_d  = 1'b0;
      end
    endcase

    // Line outputs are registered from next state so they change on the bit_en edge itself.
    se0_d = (state_d == ST_EOP1) || (state_d == ST_EOP2);
    dp_d  = se0_d ? 1'b0 : lvl_d;
    dm_d  = se0_d ? 1'b0 : ~lvl_d;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      state_q <= ST_IDLE;
      lvl_q   <= 1'b1;
      ones_q  <= '0;
      dp_q    <= 1'b1;
      dm_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lvl_q   <= lvl_d;
      ones_q  <= ones_d;
      dp_q    <= dp_d;
      dm_q    <= dm_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign dp   = dp_q;
  assign dm   = dm_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule
